// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with RAW forwarding from EX/MEM and MEM/WB into the ALU operand muxes.
// Latency: 1 cycle from id_* capture to stage outputs; alu_a/alu_b/ex_store_data are combinational on forwarding inputs.
// Backpressure: stall holds control fields while re-capturing forwarded rs1/rs2 data; flush inserts a bubble and wins over stall.
module ex_operand_stage #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [RADDR_W-1:0] id_rs1_addr,
    input  logic [RADDR_W-1:0] id_rs2_addr,
    input  logic [XLEN-1:0]    id_rs1_data,
    input  logic [XLEN-1:0]    id_rs2_data,
    input  logic [XLEN-1:0]    id_imm,
    input  logic [XLEN-1:0]    id_pc,
    input  logic [1:0]         id_a_sel,
    input  logic [1:0]         id_b_sel,
    input  logic [4:0]         id_alu_op,
    input  logic [RADDR_W-1:0] id_rd_addr,
    input  logic               id_reg_write,
    input  logic               exmem_we,
    input  logic [RADDR_W-1:0] exmem_rd,
    input  logic [XLEN-1:0]    exmem_result,
    input  logic               memwb_we,
    input  logic [RADDR_W-1:0] memwb_rd,
    input  logic [XLEN-1:0]    memwb_result,
    input  logic               stall,
    input  logic               flush,
    output logic               ex_valid,
    output logic [XLEN-1:0]    alu_a,
    output logic [XLEN-1:0]    alu_b,
    output logic [4:0]         alu_op,
    output logic [RADDR_W-1:0] ex_rd_addr,
    output logic               ex_reg_write,
    output logic [XLEN-1:0]    ex_store_data
);

    typedef struct packed {
        logic               valid;
        logic [RADDR_W-1:0] rs1_addr;
        logic [RADDR_W-1:0] rs2_addr;
        logic [XLEN-1:0]    rs1_data;
        logic [XLEN-1:0]    rs2_data;
        logic [XLEN-1:0]    imm;
        logic [XLEN-1:0]    pc;
        logic [1:0]         a_sel;
        logic [1:0]         b_sel;
        logic [4:0]         alu_op;
        logic [RADDR_W-1:0] rd_addr;
        logic               reg_write;
    } stage_t;

    stage_t            stage_q;
    stage_t            stage_d;
    logic [XLEN-1:0]   rs1_fwd;
    logic [XLEN-1:0]   rs2_fwd;

    // EX/MEM is the younger producer, so it outranks MEM/WB; x0 is hardwired zero.
    always_comb begin
        rs1_fwd = stage_q.rs1_data;
        if (stage_q.rs1_addr == '0)
            rs1_fwd = '0;
        else if (exmem_we && (exmem_rd == stage_q.rs1_addr))
            rs1_fwd = exmem_result;
        else if (memwb_we && (memwb_rd == stage_q.rs1_addr))
            rs1_fwd = memwb_result;
    end

    always_comb begin
        rs2_fwd = stage_q.rs2_data;
        if (stage_q.rs2_addr == '0)
            rs2_fwd = '0;
        else if (exmem_we && (exmem_rd == stage_q.rs2_addr))
            rs2_fwd = exmem_result;
        else if (memwb_we && (memwb_rd == stage_q.rs2_addr))
            rs2_fwd = memwb_result;
    end

    always_comb begin
        stage_d = stage_q;
        if (flush) begin
            stage_d = '0;
        end else if (stall) begin
            // Absorb forwarded values so a producer retiring during the stall is not lost.
            stage_d.rs1_data = rs1_fwd;
            stage_d.rs2_data = rs2_fwd;
        end else begin
            stage_d.valid     = id_valid;
            stage_d.rs1_addr  = id_rs1_addr;
            stage_d.rs2_addr  = id_rs2_addr;
            stage_d.rs1_data  = id_rs1_data;
            stage_d.rs2_data  = id_rs2_data;
            stage_d.imm       = id_imm;
            stage_d.pc        = id_pc;
            stage_d.a_sel     = id_a_sel;
            stage_d.b_sel     = id_b_sel;
            stage_d.alu_op    = id_alu_op;
            stage_d.rd_addr   = id_rd_addr;
            stage_d.reg_write = id_reg_write;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stage_q <= '0;
        else
            stage_q <= stage_d;
    end

    always_comb begin
        case (stage_q.a_sel)
            2'b00:   alu_a = rs1_fwd;
            2'b01:   alu_a = stage_q.pc;
            default: alu_a = '0;
        endcase
    end

    always_comb begin
        case (stage_q.b_sel)
            2'b00:   alu_b = rs2_fwd;
            2'b01:   alu_b = stage_q.imm;
            2'b10:   alu_b = XLEN'(4);
            default: alu_b = '0;
        endcase
    end

    assign ex_valid      = stage_q.valid;
    assign alu_op        = stage_q.alu_op;
    assign ex_rd_addr    = stage_q.rd_addr;
    assign ex_reg_write  = stage_q.reg_write & stage_q.valid;
    assign ex_store_data = rs2_fwd;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Randomized and directed bench for ex_operand_stage against an instruction-level reference model.
module tb_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
    logic [1:0]  id_a_sel, id_b_sel;
    logic [4:0]  id_alu_op;
    logic        id_reg_write;
    logic        exmem_we, memwb_we;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic        stall, flush;
    logic        ex_valid, ex_reg_write;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [4:0]  alu_op, ex_rd_addr;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference: the instruction currently held in EX, as last accepted.
    logic        m_valid, m_rw;
    logic [4:0]  m_rs1, m_rs2, m_rd, m_op;
    logic [31:0] m_d1, m_d2, m_imm, m_pc;
    logic [1:0]  m_asel, m_bsel;

    ex_operand_stage dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_pc(id_pc),
        .id_a_sel(id_a_sel), .id_b_sel(id_b_sel), .id_alu_op(id_alu_op),
        .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write),
        .exmem_we(exmem_we), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_we(memwb_we), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write), .ex_store_data(ex_store_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] rf);
        if (r == 5'd0) return 32'd0;
        if (exmem_we && exmem_rd == r) return exmem_result;
        if (memwb_we && memwb_rd == r) return memwb_result;
        return rf;
    endfunction

    function automatic logic [31:0] exp_a();
        if (m_asel == 2'd0) return fwd(m_rs1, m_d1);
        if (m_asel == 2'd1) return m_pc;
        return 32'd0;
    endfunction

    function automatic logic [31:0] exp_b();
        if (m_bsel == 2'd0) return fwd(m_rs2, m_d2);
        if (m_bsel == 2'd1) return m_imm;
        if (m_bsel == 2'd2) return 32'd4;
        return 32'd0;
    endfunction

    task automatic model_clear();
        m_valid = 0; m_rw = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_op = 0;
        m_d1 = 0; m_d2 = 0; m_imm = 0; m_pc = 0; m_asel = 0; m_bsel = 0;
    endtask

    task automatic model_update();
        logic [31:0] f1, f2;
        f1 = fwd(m_rs1, m_d1);
        f2 = fwd(m_rs2, m_d2);
        if (rst || flush) begin
            model_clear();
        end else if (stall) begin
            m_d1 = f1; m_d2 = f2;
        end else begin
            m_valid = id_valid; m_rw = id_reg_write; m_rs1 = id_rs1_addr; m_rs2 = id_rs2_addr;
            m_rd = id_rd_addr; m_op = id_alu_op; m_d1 = id_rs1_data; m_d2 = id_rs2_data;
            m_imm = id_imm; m_pc = id_pc; m_asel = id_a_sel; m_bsel = id_b_sel;
        end
    endtask

    // Inputs only change after the falling edge, so the model sees what the DUT sampled.
    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        id_valid = 0; id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0;
        id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_pc = 0;
        id_a_sel = 0; id_b_sel = 0; id_alu_op = 0; id_reg_write = 0;
        exmem_we = 0; exmem_rd = 0; exmem_result = 0;
        memwb_we = 0; memwb_rd = 0; memwb_result = 0;
        stall = 0; flush = 0;
    endtask

    task automatic randomize_id();
        id_valid = 1'($urandom); id_reg_write = 1'($urandom);
        id_rs1_addr = 5'($urandom_range(0, 7)); id_rs2_addr = 5'($urandom_range(0, 7));
        id_rd_addr = 5'($urandom); id_alu_op = 5'($urandom);
        id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom; id_pc = $urandom;
        id_a_sel = 2'($urandom); id_b_sel = 2'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        model_clear();
        repeat (2) @(negedge clk);
        n_checks++; if ({ex_valid, alu_op, ex_rd_addr, ex_reg_write} !== 12'd0)
            $display("FAIL reset_ctrl: got %h want 0", {ex_valid, alu_op, ex_rd_addr, ex_reg_write}); else n_pass++;
        n_checks++; if ({alu_a, alu_b, ex_store_data} !== 96'd0)
            $display("FAIL reset_data: got %h want 0", {alu_a, alu_b, ex_store_data}); else n_pass++;
        rst = 1'b0;
        // Load a live instruction, then pulse reset mid-cycle.
        id_valid = 1; id_reg_write = 1; id_rd_addr = 5'd9; id_alu_op = 5'h13;
        id_rs1_addr = 5'd2; id_rs1_data = 32'hCAFE_0001; id_rs2_addr = 5'd3; id_rs2_data = 32'h77;
        stall = 1; flush = 0;
        tick();
        stall = 0;
        tick();
        n_checks++; if (ex_valid !== 1'b1 || alu_a !== 32'hCAFE_0001)
            $display("FAIL reset_preload: got v=%b a=%h want v=1 a=cafe0001", ex_valid, alu_a); else n_pass++;
        #2 rst = 1'b1; stall = 1'b1;
        #1;
        model_clear();
        n_checks++; if ({ex_valid, alu_op, ex_rd_addr, ex_reg_write} !== 12'd0)
            $display("FAIL reset_mid_ctrl: got %h want 0", {ex_valid, alu_op, ex_rd_addr, ex_reg_write}); else n_pass++;
        n_checks++; if ({alu_a, alu_b, ex_store_data} !== 96'd0)
            $display("FAIL reset_mid_data: got %h want 0", {alu_a, alu_b, ex_store_data}); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
    endtask

    task automatic test_priority();
        id_valid = 1; id_rs1_addr = 5'd5; id_rs1_data = 32'h1234; id_a_sel = 2'b00;
        tick();
        exmem_we = 1; exmem_rd = 5'd5; exmem_result = 32'hAAAA;
        memwb_we = 1; memwb_rd = 5'd5; memwb_result = 32'hBBBB;
        #1;
        n_checks++; if (alu_a !== 32'hAAAA) $display("FAIL prio_exmem: got %h want 0000aaaa", alu_a); else n_pass++;
        exmem_we = 0; #1;
        n_checks++; if (alu_a !== 32'hBBBB) $display("FAIL prio_memwb: got %h want 0000bbbb", alu_a); else n_pass++;
        memwb_we = 0; #1;
        n_checks++; if (alu_a !== 32'h1234) $display("FAIL prio_regfile: got %h want 00001234", alu_a); else n_pass++;
        clear_inputs();
    endtask

    task automatic test_x0();
        id_valid = 1; id_rs1_addr = 5'd0; id_rs1_data = 32'h777;
        tick();
        exmem_we = 1; exmem_rd = 5'd0; exmem_result = 32'hDEAD;
        #1;
        n_checks++; if (alu_a !== 32'd0) $display("FAIL x0_no_fwd: got %h want 0", alu_a); else n_pass++;
        id_a_sel = 2'b01; id_pc = 32'h100; id_b_sel = 2'b01; id_imm = 32'h20;
        tick();
        n_checks++; if (alu_a !== 32'h100) $display("FAIL x0_pc_sel: got %h want 00000100", alu_a); else n_pass++;
        n_checks++; if (alu_b !== 32'h20) $display("FAIL x0_imm_sel: got %h want 00000020", alu_b); else n_pass++;
        id_b_sel = 2'b10;
        tick();
        n_checks++; if (alu_b !== 32'd4) $display("FAIL const4_sel: got %h want 4", alu_b); else n_pass++;
        clear_inputs();
    endtask

    task automatic test_stall();
        id_valid = 1; id_rs2_addr = 5'd7; id_rs2_data = 32'h99; id_b_sel = 2'b00;
        id_alu_op = 5'h0A; id_rd_addr = 5'd3; id_reg_write = 1;
        memwb_we = 1; memwb_rd = 5'd7; memwb_result = 32'h55;
        tick();
        n_checks++; if (alu_b !== 32'h55) $display("FAIL stall_pre: got %h want 55", alu_b); else n_pass++;
        stall = 1; id_alu_op = 5'h1F; id_rs2_data = 32'h66; id_rs2_addr = 5'd9;
        for (int c = 0; c < 3; c++) begin
            tick();
            memwb_we = 0;
            #1;
            n_checks++; if (alu_b !== 32'h55) $display("FAIL stall_alu_b[%0d]: got %h want 55", c, alu_b); else n_pass++;
            n_checks++; if (ex_store_data !== 32'h55) $display("FAIL stall_store[%0d]: got %h want 55", c, ex_store_data); else n_pass++;
            n_checks++; if (alu_op !== 5'h0A) $display("FAIL stall_op[%0d]: got %h want 0a", c, alu_op); else n_pass++;
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_flush();
        id_valid = 1; id_reg_write = 1; id_alu_op = 5'h11; id_rd_addr = 5'd4;
        tick();
        n_checks++; if (ex_reg_write !== 1'b1) $display("FAIL flush_pre: got %b want 1", ex_reg_write); else n_pass++;
        stall = 1; flush = 1;
        tick();
        n_checks++; if (ex_valid !== 1'b0) $display("FAIL flush_valid: got %b want 0", ex_valid); else n_pass++;
        n_checks++; if (ex_reg_write !== 1'b0) $display("FAIL flush_rw: got %b want 0", ex_reg_write); else n_pass++;
        n_checks++; if (alu_op !== 5'd0) $display("FAIL flush_op: got %h want 0", alu_op); else n_pass++;
        n_checks++; if (ex_rd_addr !== 5'd0) $display("FAIL flush_rd: got %h want 0", ex_rd_addr); else n_pass++;
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        logic [4:0] want_op, want_rd;
        logic       want_v, want_rw;
        for (int i = 0; i < 16; i++) begin
            randomize_id();
            want_op = id_alu_op; want_rd = id_rd_addr; want_v = id_valid; want_rw = id_reg_write & id_valid;
            tick();
            n_checks++; if ({ex_valid, alu_op, ex_rd_addr, ex_reg_write} !== {want_v, want_op, want_rd, want_rw})
                $display("FAIL b2b_ctrl[%0d]: got %h want %h", i, {ex_valid, alu_op, ex_rd_addr, ex_reg_write},
                         {want_v, want_op, want_rd, want_rw}); else n_pass++;
            n_checks++; if (alu_a !== exp_a() || alu_b !== exp_b())
                $display("FAIL b2b_ops[%0d]: got %h/%h want %h/%h", i, alu_a, alu_b, exp_a(), exp_b()); else n_pass++;
        end
        clear_inputs();
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            randomize_id();
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 7) == 0);
            tick();
            exmem_we = 1'($urandom); exmem_rd = 5'($urandom_range(0, 7)); exmem_result = $urandom;
            memwb_we = 1'($urandom); memwb_rd = 5'($urandom_range(0, 7)); memwb_result = $urandom;
            #1;
            n_checks++; if ({ex_valid, alu_op, ex_rd_addr, ex_reg_write} !== {m_valid, m_op, m_rd, m_rw & m_valid})
                $display("FAIL rand_ctrl[%0d]: got %h want %h", i, {ex_valid, alu_op, ex_rd_addr, ex_reg_write},
                         {m_valid, m_op, m_rd, m_rw & m_valid}); else n_pass++;
            n_checks++; if (alu_a !== exp_a()) $display("FAIL rand_a[%0d]: got %h want %h", i, alu_a, exp_a()); else n_pass++;
            n_checks++; if (alu_b !== exp_b()) $display("FAIL rand_b[%0d]: got %h want %h", i, alu_b, exp_b()); else n_pass++;
            n_checks++; if (ex_store_data !== fwd(m_rs2, m_d2))
                $display("FAIL rand_store[%0d]: got %h want %h", i, ex_store_data, fwd(m_rs2, m_d2)); else n_pass++;
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_priority();
        test_x0();
        test_stall();
        test_flush();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
